demux_stream_n: RTL and testbench

DEMUX_STREAM_N -- requirements
Module: demux_stream_n

---
 rtl/demux_stream_n.sv | 102 ++++++++++
 tb/tb_demux_stream_n.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/demux_stream_n.sv
// One-deep registered demultiplexer: routes each accepted beat to a single output channel
// chosen by binary index or lowest-set-bit priority, counting beats that address no channel.
module demux_stream_n #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [N_OUT-1:0] in_mask,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [N_OUT-1:0] out_valid,
    input  logic [N_OUT-1:0] out_ready,
    output logic [7:0]       drop_cnt,
    output logic             busy
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic             busy_q, busy_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       drop_q, drop_d;

    logic             tgt_ok;
    logic [SEL_W-1:0] tgt_idx;
    logic             drain;
    logic             accept;

    // Target decode on the presented beat; the descending loop leaves the lowest set bit winning.
    always_comb begin
        tgt_ok  = 1'b0;
        tgt_idx = '0;
        if (!mode) begin
            if (32'(in_sel) < N_OUT) begin
                tgt_ok  = 1'b1;
                tgt_idx = in_sel;
            end
        end else begin
            for (int k = N_OUT - 1; k >= 0; k--) begin
                if (in_mask[k]) begin
                    tgt_ok  = 1'b1;
                    tgt_idx = SEL_W'(k);
                end
            end
        end
    end

    assign drain    = busy_q & out_ready[ch_q];
    assign in_ready = ~busy_q | out_ready[ch_q];
    assign accept   = in_valid & in_ready;

    always_comb begin
        busy_d = busy_q;
        ch_d   = ch_q;
        data_d = data_q;
        drop_d = drop_q;
        if (accept && tgt_ok) begin
            busy_d = 1'b1;
            ch_d   = tgt_idx;
            data_d = in_data;
        end else if (drain) begin
            busy_d = 1'b0;
        end
        if (accept && !tgt_ok) begin
            drop_d = sat_inc(drop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            ch_q   <= '0;
            data_q <= '0;
            drop_q <= 8'd0;
        end else begin
            busy_q <= busy_d;
            ch_q   <= ch_d;
            data_q <= data_d;
            drop_q <= drop_d;
        end
    end

    always_comb begin
        out_valid = '0;
        if (busy_q) begin
            out_valid[ch_q] = 1'b1;
        end
    end

    assign out_data = data_q;
    assign drop_cnt = drop_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_demux_stream_n.sv
// Directed bench for demux_stream_n at WIDTH=8, N_OUT=4.
module tb_demux_stream_n;

    localparam int WIDTH = 8;
    localparam int N_OUT = 4;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             mode;
    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_sel;
    logic [N_OUT-1:0] in_mask;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [N_OUT-1:0] out_valid;
    logic [N_OUT-1:0] out_ready;
    logic [7:0]       drop_cnt;
    logic             busy;

    int total = 0;
    int bad   = 0;

    demux_stream_n #(.WIDTH(WIDTH), .N_OUT(N_OUT)) dut (
        .clk(clk), .reset(reset), .mode(mode), .in_data(in_data), .in_sel(in_sel),
        .in_mask(in_mask), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b0; in_data = 8'h00; in_sel = 2'd0; in_mask = 4'b0000;
        in_valid = 1'b0; out_ready = 4'b0000;
        step(); step();
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_binary();
        mode = 1'b0; in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1; out_ready = 4'b0000;
        step();
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 4'b0100) begin bad++; $display("FAIL bin_out_valid got=%b exp=0100", out_valid); end
        total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL bin_out_data got=%h exp=a5", out_data); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bin_busy got=%b exp=1", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bin_in_ready got=%b exp=0", in_ready); end
        // Blocked beat and a non-selected ready must leave the register untouched.
        in_sel = 2'd1; in_data = 8'h11; in_valid = 1'b1; out_ready = 4'b1011;
        step();
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 4'b0100) begin bad++; $display("FAIL hold_out_valid got=%b exp=0100", out_valid); end
        total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL hold_out_data got=%h exp=a5", out_data); end
        out_ready = 4'b0100;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_in_ready got=%b exp=1", in_ready); end
        step();
        out_ready = 4'b0000;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%b exp=0", busy); end
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL drain_out_valid got=%b exp=0000", out_valid); end
        total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL empty_out_data got=%h exp=a5", out_data); end
    endtask

    task automatic test_priority();
        mode = 1'b1; in_mask = 4'b1010; in_data = 8'h3C; in_valid = 1'b1; out_ready = 4'b0000;
        step();
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 4'b0010) begin bad++; $display("FAIL prio_out_valid got=%b exp=0010", out_valid); end
        total++; if (out_data !== 8'h3C) begin bad++; $display("FAIL prio_out_data got=%h exp=3c", out_data); end
        out_ready = 4'b1000;
        step();
        total++; if (out_valid !== 4'b0010) begin bad++; $display("FAIL prio_other_ready got=%b exp=0010", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL prio_in_ready got=%b exp=0", in_ready); end
        out_ready = 4'b0010;
        step();
        out_ready = 4'b0000;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL prio_drain_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        mode = 1'b0; in_sel = 2'd1; out_ready = 4'b0010;
        for (int i = 1; i <= 8; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready beat=%0d got=%b exp=1", i, in_ready); end
            step();
            total++; if (out_valid !== 4'b0010 || out_data !== 8'(i))
                begin bad++; $display("FAIL stream_out beat=%0d got=%b/%h exp=0010/%h", i, out_valid, out_data, 8'(i)); end
        end
        in_valid = 1'b0;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stream_end_busy got=%b exp=0", busy); end
        out_ready = 4'b0000;
    endtask

    task automatic test_drop_sat();
        int exp_cnt;
        mode = 1'b1; in_mask = 4'b0000; in_data = 8'hEE; in_valid = 1'b1; out_ready = 4'b0000;
        for (int i = 1; i <= 300; i++) begin
            step();
            exp_cnt = (i > 255) ? 255 : i;
            if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
                total++; if (drop_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL drop_cnt iter=%0d got=%0d exp=%0d", i, drop_cnt, exp_cnt); end
                total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL drop_out_valid iter=%0d got=%b exp=0000", i, out_valid); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_drain_invalid();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mode = 1'b0; in_sel = 2'd0; in_data = 8'h77; in_valid = 1'b1; out_ready = 4'b0000;
        step();
        total++; if (out_valid !== 4'b0001 || drop_cnt !== 8'd0) begin bad++; $display("FAIL load77 got=%b/%0d exp=0001/0", out_valid, drop_cnt); end
        mode = 1'b1; in_mask = 4'b0000; in_data = 8'h99; out_ready = 4'b0001;
        step();
        in_valid = 1'b0; out_ready = 4'b0000;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_inv_busy got=%b exp=0", busy); end
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL drain_inv_drop got=%0d exp=1", drop_cnt); end
        total++; if (out_data !== 8'h77) begin bad++; $display("FAIL drain_inv_data got=%h exp=77", out_data); end
    endtask

    task automatic test_reset_full();
        mode = 1'b0; in_sel = 2'd3; in_data = 8'h5A; in_valid = 1'b1; out_ready = 4'b0000;
        step();
        total++; if (out_valid !== 4'b1000) begin bad++; $display("FAIL rst_full_load got=%b exp=1000", out_valid); end
        reset = 1'b1; in_sel = 2'd1; in_data = 8'h99; out_ready = 4'b1111;
        step();
        reset = 1'b1; mode = 1'b1; in_mask = 4'b0000;
        step();
        reset = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
        #1;
        total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rst_full_out_valid got=%b exp=0000", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_full_out_data got=%h exp=00", out_data); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_full_drop got=%0d exp=0", drop_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_full_in_ready got=%b exp=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_full_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_binary();
        test_priority();
        test_back_to_back();
        test_drop_sat();
        test_drain_invalid();
        test_reset_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
